lfsr_bist_ctrl: RTL
===================

Name: lfsr_bist_ctrl

Overview:
Built-in self-test sequencer for one `lfsr` instance, which has a zero-inclusive sequence of period 2^WIDTH. On a start command it holds the LFSR in reset, then runs it for exactly one period. While it runs it checks three things: the sequence starts at zero, it never revisits zero early, and it returns to zero on the exact final step. It sits between the system controller and the LFSR and is the synthesizable replacement for bench-only period checking.

Parameters:
- WIDTH, 8, width of the LFSR under test; the expected period is 2^WIDTH.
- RST_CYCLES, 2, number of cycles lfsr_rst is held in the RESET state (minimum 1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a test; sampled only in IDLE.
- abort  in  1  terminate a running test; sampled in RESET and RUN.
- lfsr_rst  out  1  registered reset to the LFSR instance.
- lfsr_out  in  WIDTH  current LFSR state (the `out` of the instance).
- busy  out  1  high in RESET and RUN.
- done  out  1  one-cycle pulse in DONE.
- pass  out  1  result of the last test; held until the next start.
- err  out  4  {abort, late, early, seed}; held until the next start.
- zero_cycle  out  WIDTH+1  step index of the first non-initial zero seen in the last test.

Behaviour:
- Reset values:
  - State IDLE.
  - lfsr_rst=1.
  - busy=0, done=0, pass=0, err=0, zero_cycle=0.
  - Step counter cnt (WIDTH+1 bits) = 0.
- LFSR reset control: lfsr_rst=1 in IDLE, RESET and DONE; lfsr_rst=0 only in RUN.
- IDLE:
  - start=1 → RESET. On the same edge: pass and err clear, zero_cycle clears, rst-cycle counter loads.
  - abort is ignored in IDLE.
- RESET:
  - Lasts RST_CYCLES cycles, then → RUN with cnt=0.
  - abort=1 → DONE with err[3]=1.
- RUN (one step per cycle; lfsr_out is compared on the edge ending step cnt=k):
  - k=0, lfsr_out≠0 → err[0] (seed) set, → DONE.
  - 1≤k≤2^WIDTH−1, lfsr_out==0 → err[1] (early) set, zero_cycle=k, → DONE immediately.
  - k=2^WIDTH, lfsr_out==0 → pass=1, zero_cycle=k, → DONE.
  - k=2^WIDTH, lfsr_out≠0 → err[2] (late) set, → DONE.
  - Otherwise cnt increments.
  - abort=1 in any RUN cycle overrides every check: only err[3] set, pass=0, → DONE.
- DONE: done=1 for one cycle, → IDLE unconditionally. A start asserted during DONE is ignored.
- Result invariants:
  - pass=1 implies err=0.
  - Exactly one err bit is set on a failing test.
- Latency:
  - For a passing test, done is high in cycle start_edge + 2^WIDTH + RST_CYCLES + 1.
  - Example: WIDTH=4, RST_CYCLES=2 gives 19 cycles.
- Counter: cnt is WIDTH+1 bits, so 2^WIDTH is representable; it never wraps within a test.
- start while busy: ignored, no restart.
- rst mid-test: immediate return to the reset values above, with lfsr_rst=1 on the next cycle.

Test Plan:
- WIDTH=4, RST_CYCLES=2, real `lfsr`; pulse start → done at start+19; pass=1, err=0000, zero_cycle=16; lfsr_rst low for exactly 17 cycles.
- Stub lfsr_out=0 at k=0, 0 again at k=7 → done one cycle after the k=7 edge; err=0010, zero_cycle=7, pass=0.
- Stub never returns to zero (0 at k=0, nonzero through k=16) → err=0100, pass=0, done at start+19.
- Stub lfsr_out=5 at k=0 → err=0001, DONE right after the first RUN cycle.
- abort at RUN k=16 while lfsr_out=0 → err=1000, pass=0. abort during RESET → err=1000 and RUN is never entered.
- Combined start/busy/reset case:
  - start held high for the whole test → exactly one test runs.
  - start pulsed during RUN → no restart.
  - rst at k=10 → busy=0, lfsr_rst=1, all results 0 on the next cycle.

Source files
------------

// File: rtl/lfsr_bist_ctrl_if.sv
// Control/status and LFSR-side signals of the LFSR BIST sequencer.
// slave is the sequencer's view; master is the system controller / LFSR side.
interface lfsr_bist_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic             lfsr_rst;
  logic [WIDTH-1:0] lfsr_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [3:0]       err;
  logic [WIDTH:0]   zero_cycle;

  modport slave (
    input  start, abort, lfsr_out,
    output lfsr_rst, busy, done, pass, err, zero_cycle
  );

  modport master (
    output start, abort, lfsr_out,
    input  lfsr_rst, busy, done, pass, err, zero_cycle
  );
endinterface

// File: rtl/lfsr_bist_ctrl.sv
// Runs one LFSR for exactly one 2^WIDTH period after a held reset and checks
// that zero appears only at step 0 and step 2^WIDTH; err = {abort, late, early, seed}.
module lfsr_bist_ctrl #(
  parameter int WIDTH      = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  lfsr_bist_ctrl_if.slave        bus
);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [WIDTH:0] PERIOD = {1'b1, {WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [RW-1:0]  rcnt_q, rcnt_d;
  logic [WIDTH:0] cnt_q, cnt_d;
  logic           lfsr_rst_q, lfsr_rst_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [3:0]     err_q, err_d;
  logic [WIDTH:0] zc_q, zc_d;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    zc_d    = zc_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RESET;
          rcnt_d  = RW'(RST_CYCLES - 1);
          pass_d  = 1'b0;
          err_d   = 4'b0000;
          zc_d    = '0;
        end
      end
      RESET: begin
        if (bus.abort) begin
          err_d   = 4'b1000;
          state_d = DONE;
        end else if (rcnt_q == '0) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          rcnt_d  = rcnt_q - 1'b1;
        end
      end
      RUN: begin
        // abort wins over whatever the step check would have concluded
        if (bus.abort) begin
          err_d   = 4'b1000;
          pass_d  = 1'b0;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          if (bus.lfsr_out != '0) begin
            err_d   = 4'b0001;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end else if (cnt_q == PERIOD) begin
          if (bus.lfsr_out == '0) begin
            pass_d  = 1'b1;
            zc_d    = cnt_q;
          end else begin
            err_d   = 4'b0100;
          end
          state_d = DONE;
        end else if (bus.lfsr_out == '0) begin
          err_d   = 4'b0010;
          zc_d    = cnt_q;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they align with it.
    lfsr_rst_d = (state_d != RUN);
    busy_d     = (state_d == RESET) || (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rcnt_q     <= '0;
      cnt_q      <= '0;
      lfsr_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 4'b0000;
      zc_q       <= '0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      cnt_q      <= cnt_d;
      lfsr_rst_q <= lfsr_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      zc_q       <= zc_d;
    end
  end

  assign bus.lfsr_rst   = lfsr_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err        = err_q;
  assign bus.zero_cycle = zc_q;
endmodule
